inst_rom_loader: RTL and testbench
==================================

Name: inst_rom_loader

Overview:
- Writer side of the instruction memory: receives a byte stream, packs it into 32-bit instruction words and writes them into the 64-word instruction RAM.
- The fetch unit's PC[7:2] then reads these words back.
- Holds the CPU in reset until a complete program image has been written.
- Sits between the byte source (UART receiver or bench) and the instruction RAM write port (port B of the fetch RAM).

Parameters:
- ADDR_W, 6, word address width (64 words; matches PC[7:2])
- DATA_W, 32, instruction word width; fixed at 4 bytes per word

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE, DONE, ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- we  out  1  RAM write enable (one-cycle pulse per word)
- addr  out  ADDR_W  RAM word address
- wdata  out  DATA_W  RAM write data
- busy  out  1  load in progress
- done  out  1  last load completed successfully (level)
- err  out  1  last load failed (level)
- cpu_rst  out  1  CPU reset request
- word_cnt  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rx_ready=0, we=0, addr=0, wdata=0.
  - busy=0, done=0, err=0, word_cnt=0.
  - cpu_rst=1: CPU stays in reset until the first good load.
- Byte transfer occurs on a rising edge with rx_valid && rx_ready. rx_data must be stable while rx_valid=1.
- Stream format:
  - Byte 0 is the length N. N=0 means 64 words; otherwise N words (1..63).
  - Then 4N data bytes per word, MSB first: first byte lands in wdata[31:24].
- States:
  - IDLE: rx_ready=0. start -> LEN; set busy=1, cpu_rst=1, done=0, err=0, addr=0, word_cnt=0.
  - LEN: rx_ready=1. On transfer, latch N and go to DATA with byte index 0.
  - DATA: rx_ready=1. Each transfer shifts the byte into the word register. On the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - rx_ready=0, we=1, addr=current word address, wdata=assembled word.
    - Next cycle: addr+1, word_cnt+1.
    - If word_cnt+1==N (64 when N=0), go to DONE; else go to DATA.
  - DONE: busy=0, done=1, cpu_rst=0, rx_ready=0. start -> LEN (reload).
  - ERR: busy=0, err=1, cpu_rst=1, rx_ready=0. start -> LEN.
- Latency: 4th byte transfer at edge k gives we=1 in cycle k+1. Max throughput is 1 word per 5 cycles.
- Address wrap: addr is ADDR_W bits. After word 63 it wraps to 0, which only happens at completion when N=0.
- start while busy is ignored.
- rx_valid idle gaps of any length are legal; state is held.
- rst mid-load: immediately IDLE, cpu_rst=1. Partially written RAM contents are not cleared.
- Bytes offered in IDLE/DONE/ERR are not accepted (rx_ready=0).

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the data: the XOR of all 4N data bytes.
  - After the last WRITE, state CHECK raises rx_ready=1 and receives this byte.
  - Match -> DONE. Mismatch -> ERR; cpu_rst stays 1 and word_cnt keeps N.
- Undefined:
  - No CHECK state and no checksum byte.
  - The ERR state is unreachable but encoded.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR (3-bit)
  - INST_ADDR_W=6, INST_W=32, BYTES_PER_WORD=4
- Sub-module byte_packer: 4-byte shift register with 2-bit index and a full flag, reused later by the data-memory loader.

Test Plan:
- Reset check: rst pulse -> cpu_rst=1, busy=0, done=0, we=0, addr=0.
- Basic load, N=2:
  - start; bytes 02, 12 34 56 78, 9A BC DE F0 (contiguous valid).
  - Expect we pulses at addr 0 with 0x12345678 and at addr 1 with 0x9ABCDEF0.
  - Then done=1, cpu_rst=0, word_cnt=2.
- Back-pressure/gaps, N=1:
  - rx_valid toggled 1-0-0-1 per byte.
  - Single write of the correct word; rx_ready=0 during the WRITE cycle; no byte lost.
- Full image, N=0: 256 data bytes -> 64 writes at addr 0..63, word_cnt=64, addr wraps to 0, done=1.
- Reset mid-load: rst asserted after 5 of 8 data bytes -> IDLE, cpu_rst=1, done=0. A fresh start reloads correctly.
- Checksum (INST_LOADER_CHECKSUM_EN), N=1, data 01 02 03 04:
  - Checksum 0x04 -> done=1.
  - Checksum 0x05 -> err=1, cpu_rst=1.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared constants, FSM state encoding and helpers for
// the instruction-memory loader and its byte packer.
//   INST_ADDR_W    : word address width of the instruction RAM (PC[7:2])
//   INST_W         : instruction word width
//   BYTES_PER_WORD : stream bytes per instruction word (MSB first)
package inst_rom_loader_pkg;

  localparam int unsigned INST_ADDR_W    = 6;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTE_IDX_W     = 2;
  localparam int unsigned WORD_CNT_W     = INST_ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // Image length in words from the low bits of the length byte; 0 means a full RAM.
  function automatic logic [WORD_CNT_W-1:0] image_words(input logic [INST_ADDR_W-1:0] len);
    if (len == '0) return WORD_CNT_W'(1 << INST_ADDR_W);
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// inst_rom_loader_if: byte-stream input and RAM write port of the loader.
//   rx_data/rx_valid/rx_ready : byte stream, transfer on valid && ready
//   we/addr/wdata             : instruction RAM write port (port B)
// Modports: slave = loader, master = byte source / RAM side.
interface inst_rom_loader_if;
  import inst_rom_loader_pkg::*;

  logic [BYTE_W-1:0]      rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   we;
  logic [INST_ADDR_W-1:0] addr;
  logic [INST_W-1:0]      wdata;

  modport slave  (input  rx_data, rx_valid, output rx_ready, we, addr, wdata);
  modport master (output rx_data, rx_valid, input  rx_ready, we, addr, wdata);

endinterface

// File: rtl/inst_rom_loader_byte_packer.sv
// inst_rom_loader_byte_packer: packs bytes MSB-first into a 32-bit word.
//   clk, rst  : clock, async active-high reset
//   clr_i     : restart at byte index 0
//   push_i    : shift byte_i into the word
//   byte_i    : incoming byte
//   word_o    : assembled word (registered)
//   full_c_o  : this push completes a word (combinational)
module inst_rom_loader_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              full_c_o
);

  logic [INST_W-1:0]     word_q;
  logic [BYTE_IDX_W-1:0] idx_q;

  // Shift register plus byte index; the index wraps after the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (push_i) begin
      word_q <= {word_q[INST_W-BYTE_W-1:0], byte_i};
      idx_q  <= idx_q + BYTE_IDX_W'(1);
    end
  end

  assign word_o   = word_q;
  assign full_c_o = push_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: receives a length-prefixed byte stream, packs it into
// 32-bit words and writes them into the 64-word instruction RAM, holding the
// CPU in reset until a complete image has been loaded.
//   clk, rst    : clock, async active-high reset
//   start_i     : begin a load (honoured only in IDLE/DONE/ERR)
//   bus         : byte stream in, RAM write port out (inst_rom_loader_if.slave)
//   busy_o      : load in progress
//   done_o      : last load completed successfully
//   err_o       : last load failed (checksum mismatch)
//   cpu_rst_o   : CPU reset request
//   word_cnt_o  : words written in the current/last load
// Build option: INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  inst_rom_loader_if.slave      bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_rst_o,
  output logic [WORD_CNT_W-1:0] word_cnt_o
);

  state_e                 state_q;
  logic                   rx_ready_q;
  logic                   we_q;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic                   busy_q, done_q, err_q, cpu_rst_q;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [WORD_CNT_W-1:0]  len_q;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]      csum_q;
`endif

  logic              xfer_c, start_c, pk_push, pk_full;
  logic [INST_W-1:0] pk_word;

  assign xfer_c     = bus.rx_valid && rx_ready_q;
  assign start_c    = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign pk_push    = xfer_c && (state_q == ST_DATA);
  assign addr_d     = addr_q + INST_ADDR_W'(1);
  assign word_cnt_d = word_cnt_q + WORD_CNT_W'(1);

  inst_rom_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (start_c),
    .push_i   (pk_push),
    .byte_i   (bus.rx_data),
    .word_o   (pk_word),
    .full_c_o (pk_full)
  );

  // Load sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
      word_cnt_q <= '0;
      len_q      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_c) begin
            state_q    <= ST_LEN;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            word_cnt_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (xfer_c) begin
            len_q   <= image_words(bus.rx_data[INST_ADDR_W-1:0]);
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer_c) begin
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.rx_data;
`endif
            // Word completes on this edge: pulse we in the following cycle.
            if (pk_full) begin
              state_q    <= ST_WRITE;
              rx_ready_q <= 1'b0;
              we_q       <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          addr_q     <= addr_d;
          word_cnt_q <= word_cnt_d;
          if (word_cnt_d == len_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_q    <= ST_CHECK;
            rx_ready_q <= 1'b1;
`else
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_rst_q  <= 1'b0;
`endif
          end else begin
            state_q    <= ST_DATA;
            rx_ready_q <= 1'b1;
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer_c) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cpu_rst_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.wdata    = pk_word;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: randomized self-checking bench for inst_rom_loader.
// The reference model derives the expected RAM writes directly from the byte
// image (word w = bytes 4w..4w+3, MSB first, at address w mod 64).
// With INST_LOADER_CHECKSUM_EN defined the stream carries a trailing XOR byte.
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err, cpu_rst;
  logic [WORD_CNT_W-1:0] word_cnt;

  inst_rom_loader_if bus ();

  inst_rom_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .cpu_rst_o  (cpu_rst),
    .word_cnt_o (word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rdy_we_cnt = 0;

  logic [7:0]             data_q[$];
  logic [INST_ADDR_W-1:0] exp_addr_q[$], obs_addr_q[$];
  logic [INST_W-1:0]      exp_data_q[$], obs_data_q[$];
  int                     xfer_edge_q[$], wr_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: byte transfers (edge index) and RAM writes (cycle index).
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) xfer_edge_q.push_back(cyc + 1);
    if (bus.we) begin
      obs_addr_q.push_back(bus.addr);
      obs_data_q.push_back(bus.wdata);
      wr_cyc_q.push_back(cyc);
      if (bus.rx_ready) rdy_we_cnt++;
    end
  end

  task automatic clear_obs();
    obs_addr_q.delete(); obs_data_q.delete();
    xfer_edge_q.delete(); wr_cyc_q.delete();
    rdy_we_cnt = 0;
  endtask

  task automatic rand_data(input int n_bytes);
    data_q.delete();
    for (int i = 0; i < n_bytes; i++) data_q.push_back(8'($urandom));
  endtask

  // Reference model: expected write sequence for an image of n_words words.
  task automatic build_expected(input int n_words);
    exp_addr_q.delete(); exp_data_q.delete();
    for (int w = 0; w < n_words; w++) begin
      exp_addr_q.push_back(INST_ADDR_W'(w % 64));
      exp_data_q.push_back({data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.rx_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL byte_accept byte %02h not accepted within 100 cycles", b);
    end
  endtask

  task automatic gap(input int mode);
    int n;
    n = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    if (n > 0) begin
      bus.rx_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
    end
  endtask

  // Drive start, length byte, data bytes (and checksum byte when enabled).
  task automatic load_image(input logic [7:0] n, input int mode, input bit bad_csum, input bit poke);
    logic [7:0] cs;
    cs = 8'h00;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(n);
    gap(mode);
    for (int i = 0; i < data_q.size(); i++) begin
      if (poke && i == 1) start = 1'b1;
      send_byte(data_q[i]);
      start = 1'b0;
      cs = cs ^ data_q[i];
      gap(mode);
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(cs ^ {7'b0, bad_csum});
`else
    if (bad_csum) cs = ~cs;
`endif
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_finish();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL finish_timeout busy still %0b after 50 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cpu_rst, busy, done, err, bus.we, bus.rx_ready, bus.addr, word_cnt, bus.wdata}
        !== {1'b1, 5'b0, 6'd0, 7'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_state got rst=%0b busy=%0b done=%0b err=%0b we=%0b rdy=%0b addr=%0d cnt=%0d wdata=%08h want 1 0 0 0 0 0 0 0 0",
               cpu_rst, busy, done, err, bus.we, bus.rx_ready, bus.addr, word_cnt, bus.wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cpu_rst, busy, bus.rx_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL idle_hold got cpu_rst=%0b busy=%0b rdy=%0b want 1 0 0", cpu_rst, busy, bus.rx_ready);
    end
  endtask

  task automatic test_basic();
    clear_obs();
    data_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    load_image(8'd2, 0, 1'b0, 1'b0);
    wait_finish();
    build_expected(2);
    n_cmp++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      n_err++;
      $display("FAIL basic_wr_count got %0d want %0d", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
        n_err++;
        $display("FAIL basic_wr[%0d] got %0d:%08h want %0d:%08h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
      n_cmp++;
      if (xfer_edge_q.size() > 4*i+4 && wr_cyc_q[i] != xfer_edge_q[4*i+4]) begin
        n_err++;
        $display("FAIL basic_latency[%0d] we in cycle %0d want %0d", i, wr_cyc_q[i], xfer_edge_q[4*i+4]);
      end
    end
    n_cmp++;
    if ({busy, done, err, cpu_rst, word_cnt, bus.addr} !== {4'b0100, 7'd2, 6'd2}) begin
      n_err++;
      $display("FAIL basic_final got busy=%0b done=%0b err=%0b cpu_rst=%0b cnt=%0d addr=%0d want 0 1 0 0 2 2",
               busy, done, err, cpu_rst, word_cnt, bus.addr);
    end
  endtask

  task automatic test_gaps();
    clear_obs();
    rand_data(4);
    load_image(8'd1, 1, 1'b0, 1'b0);
    wait_finish();
    build_expected(1);
    n_cmp++;
    if (obs_addr_q.size() != 1 || obs_data_q.size() != 1) begin
      n_err++;
      $display("FAIL gaps_wr_count got %0d want 1", obs_addr_q.size());
    end else if (obs_addr_q[0] !== exp_addr_q[0] || obs_data_q[0] !== exp_data_q[0]) begin
      n_err++;
      $display("FAIL gaps_wr got %0d:%08h want %0d:%08h", obs_addr_q[0], obs_data_q[0], exp_addr_q[0], exp_data_q[0]);
    end
    n_cmp++;
    if (rdy_we_cnt != 0) begin
      n_err++;
      $display("FAIL gaps_ready_in_write got %0d cycles with rx_ready during we want 0", rdy_we_cnt);
    end
    n_cmp++;
    if ({done, cpu_rst, word_cnt} !== {2'b10, 7'd1}) begin
      n_err++;
      $display("FAIL gaps_final got done=%0b cpu_rst=%0b cnt=%0d want 1 0 1", done, cpu_rst, word_cnt);
    end
  endtask

  task automatic test_full();
    clear_obs();
    rand_data(256);
    load_image(8'd0, 0, 1'b0, 1'b0);
    wait_finish();
    build_expected(64);
    n_cmp++;
    if (obs_addr_q.size() != 64) begin
      n_err++;
      $display("FAIL full_wr_count got %0d want 64", obs_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
        n_err++;
        $display("FAIL full_wr[%0d] got %0d:%08h want %0d:%08h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != 5) begin
          n_err++;
          $display("FAIL full_rate[%0d] write spacing got %0d cycles want 5", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
        end
      end
    end
    n_cmp++;
    if ({busy, done, err, cpu_rst, word_cnt, bus.addr} !== {4'b0100, 7'd64, 6'd0}) begin
      n_err++;
      $display("FAIL full_final got busy=%0b done=%0b err=%0b cpu_rst=%0b cnt=%0d addr=%0d want 0 1 0 0 64 0",
               busy, done, err, cpu_rst, word_cnt, bus.addr);
    end
  endtask

  task automatic test_idle_ignore();
    int rdy_seen;
    clear_obs();
    rdy_seen = 0;
    @(posedge clk); #1;
    bus.rx_data  = 8'($urandom);
    bus.rx_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.rx_ready) rdy_seen++;
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    n_cmp++;
    if (rdy_seen != 0 || xfer_edge_q.size() != 0 || obs_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_ignore got ready=%0d xfers=%0d writes=%0d want 0 0 0", rdy_seen, xfer_edge_q.size(), obs_addr_q.size());
    end
    n_cmp++;
    if ({done, word_cnt} !== {1'b1, 7'd64}) begin
      n_err++;
      $display("FAIL idle_hold_done got done=%0b cnt=%0d want 1 64", done, word_cnt);
    end
  endtask

  task automatic test_reset_mid();
    rand_data(8);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'd2);
    for (int i = 0; i < 5; i++) send_byte(data_q[i]);
    bus.rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_rst, busy, done, bus.rx_ready, bus.we, word_cnt} !== {1'b1, 4'b0, 7'd0}) begin
      n_err++;
      $display("FAIL midrst_async got cpu_rst=%0b busy=%0b done=%0b rdy=%0b we=%0b cnt=%0d want 1 0 0 0 0 0",
               cpu_rst, busy, done, bus.rx_ready, bus.we, word_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    rand_data(8);
    load_image(8'd2, 2, 1'b0, 1'b0);
    wait_finish();
    build_expected(2);
    n_cmp++;
    if (obs_addr_q.size() != 2) begin
      n_err++;
      $display("FAIL midrst_wr_count got %0d want 2", obs_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
        n_err++;
        $display("FAIL midrst_wr[%0d] got %0d:%08h want %0d:%08h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    n_cmp++;
    if ({done, cpu_rst, word_cnt} !== {2'b10, 7'd2}) begin
      n_err++;
      $display("FAIL midrst_final got done=%0b cpu_rst=%0b cnt=%0d want 1 0 2", done, cpu_rst, word_cnt);
    end
  endtask

  task automatic test_random_loads();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 8));
      clear_obs();
      rand_data(4 * n);
      load_image(8'(n), 2, 1'b0, it[0]);
      wait_finish();
      build_expected(n);
      n_cmp++;
      if (obs_addr_q.size() != n) begin
        n_err++;
        $display("FAIL rand%0d_wr_count got %0d want %0d", it, obs_addr_q.size(), n);
      end
      for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
        n_cmp++;
        if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
          n_err++;
          $display("FAIL rand%0d_wr[%0d] got %0d:%08h want %0d:%08h", it, i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
      n_cmp++;
      if ({busy, done, err, cpu_rst, word_cnt, bus.addr} !== {4'b0100, 7'(n), 6'(n)}) begin
        n_err++;
        $display("FAIL rand%0d_final got busy=%0b done=%0b err=%0b cpu_rst=%0b cnt=%0d addr=%0d want 0 1 0 0 %0d %0d",
                 it, busy, done, err, cpu_rst, word_cnt, bus.addr, n, n);
      end
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_obs();
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_image(8'd1, 0, 1'b0, 1'b0);
    wait_finish();
    n_cmp++;
    if ({done, err, cpu_rst, word_cnt} !== {3'b100, 7'd1}) begin
      n_err++;
      $display("FAIL csum_good got done=%0b err=%0b cpu_rst=%0b cnt=%0d want 1 0 0 1", done, err, cpu_rst, word_cnt);
    end
    load_image(8'd1, 0, 1'b1, 1'b0);
    wait_finish();
    n_cmp++;
    if ({busy, done, err, cpu_rst, word_cnt} !== {4'b0011, 7'd1}) begin
      n_err++;
      $display("FAIL csum_bad got busy=%0b done=%0b err=%0b cpu_rst=%0b cnt=%0d want 0 0 1 1 1",
               busy, done, err, cpu_rst, word_cnt);
    end
    load_image(8'd1, 2, 1'b0, 1'b0);
    wait_finish();
    n_cmp++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      n_err++;
      $display("FAIL csum_reload got done=%0b err=%0b cpu_rst=%0b want 1 0 0", done, err, cpu_rst);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full();
    test_idle_ignore();
    test_reset_mid();
    test_random_loads();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
